sdram_pingpong_sched: RTL and testbench

SDRAM_PINGPONG_SCHED -- requirements
Module: sdram_pingpong_sched

---
 rtl/sdram_pingpong_sched_pkg.sv | 14 +
 rtl/sdram_pingpong_sched_frame_cnt.sv | 22 ++
 rtl/sdram_pingpong_sched.sv | 126 ++++++++++++
 tb/tb_sdram_pingpong_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sdram_pingpong_sched_pkg.sv
// sdram_pingpong_sched_pkg: shared SDRAM constants, scheduler state encoding and bank helpers
package sdram_pingpong_sched_pkg;
  localparam int SDRAM_BANK_W = 2;
  localparam logic [SDRAM_BANK_W-1:0] BANK_A = 2'd0;
  localparam logic [SDRAM_BANK_W-1:0] BANK_B = 2'd1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_BUSY = 2'd2
  } state_t;
  function automatic logic [SDRAM_BANK_W-1:0] other_bank(input logic [SDRAM_BANK_W-1:0] b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction
endpackage

// File: rtl/sdram_pingpong_sched_frame_cnt.sv
// pp_frame_cnt: row-within-frame counter with wrap and one-cycle frame-end pulse
module pp_frame_cnt #(
  parameter int FRAME_BURSTS = 1200,
  parameter int ROW_W        = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [ROW_W-1:0] row,
  output logic             frame_end
);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(FRAME_BURSTS - 1);
  logic [ROW_W-1:0] row_q, row_d;
  assign frame_end = adv && (row_q == LAST);
  assign row       = row_q;
  // advance one row per completed burst, wrapping to row 0 at the frame end
  always_comb row_d = frame_end ? '0 : adv ? row_q + 1'b1 : row_q;
  // row register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
endmodule

// File: rtl/sdram_pingpong_sched.sv
// sdram_pingpong_sched: round-robin write/read burst scheduler over a two-bank SDRAM ping-pong frame buffer
// Optional PINGPONG_DROP_CNT_EN adds a saturating frame_drop_cnt output.
module sdram_pingpong_sched
  import sdram_pingpong_sched_pkg::*;
#(
  parameter int FRAME_BURSTS = 1200,
  parameter int ROW_W        = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_end,
  input  logic                    wr_rdy,
  input  logic                    rd_rdy,
  input  logic                    wr_burst_end,
  input  logic                    rd_burst_end,
  output logic                    wr_trig,
  output logic                    rd_trig,
  output logic [SDRAM_BANK_W-1:0] wr_bank,
  output logic [SDRAM_BANK_W-1:0] rd_bank,
  output logic [ROW_W-1:0]        wr_row,
  output logic [ROW_W-1:0]        rd_row,
  output logic                    frame_valid
`ifdef PINGPONG_DROP_CNT_EN
  ,
  output logic [15:0]             frame_drop_cnt
`endif
);
  state_t state_q, state_d;
  logic gnt_wr_q, gnt_wr_d;
  logic last_rd_q, last_rd_d;
  logic wr_trig_q, wr_trig_d;
  logic rd_trig_q, rd_trig_d;
  logic frame_valid_q, frame_valid_d;
  logic [SDRAM_BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [SDRAM_BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [SDRAM_BANK_W-1:0] newest_bank_q, newest_bank_d;
  logic wr_cand, rd_cand, grant_wr, grant_rd, wr_adv, rd_adv, wr_fe, rd_fe_unused, hold;

  assign wr_cand  = wr_rdy;
  assign rd_cand  = rd_rdy && frame_valid_q;
  assign grant_wr = (state_q == S_ARB) && wr_cand && (!rd_cand || last_rd_q);
  assign grant_rd = (state_q == S_ARB) && rd_cand && !grant_wr;
  assign wr_adv   = (state_q == S_BUSY) && gnt_wr_q && wr_burst_end;
  assign rd_adv   = (state_q == S_BUSY) && !gnt_wr_q && rd_burst_end;
  assign hold     = (rd_bank_q == other_bank(wr_bank_q)) && (rd_row != '0);

  pp_frame_cnt #(.FRAME_BURSTS(FRAME_BURSTS), .ROW_W(ROW_W)) u_wr_cnt (
    .clk(clk), .rst_n(rst_n), .adv(wr_adv), .row(wr_row), .frame_end(wr_fe)
  );
  pp_frame_cnt #(.FRAME_BURSTS(FRAME_BURSTS), .ROW_W(ROW_W)) u_rd_cnt (
    .clk(clk), .rst_n(rst_n), .adv(rd_adv), .row(rd_row), .frame_end(rd_fe_unused)
  );

  // scheduler FSM: grant one burst at a time, trig registered on the ARB->BUSY transition
  always_comb begin
    state_d   = state_q;
    gnt_wr_d  = gnt_wr_q;
    last_rd_d = last_rd_q;
    wr_trig_d = 1'b0;
    rd_trig_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = init_end ? S_ARB : S_IDLE;
      S_ARB: begin
        if (grant_wr || grant_rd) begin
          state_d   = S_BUSY;
          gnt_wr_d  = grant_wr;
          last_rd_d = grant_rd;
          wr_trig_d = grant_wr;
          rd_trig_d = grant_rd;
        end
      end
      S_BUSY: state_d = (wr_adv || rd_adv) ? S_ARB : S_BUSY;
      default: state_d = S_IDLE;
    endcase
  end

  // bank ping-pong: swap write bank at frame end unless the reader is mid-frame there; reader follows newest frame
  always_comb begin
    frame_valid_d = frame_valid_q || wr_fe;
    newest_bank_d = wr_fe ? wr_bank_q : newest_bank_q;
    wr_bank_d     = (wr_fe && !hold) ? other_bank(wr_bank_q) : wr_bank_q;
    rd_bank_d     = (grant_rd && rd_row == '0 && newest_bank_q != wr_bank_q) ? newest_bank_q : rd_bank_q;
  end

  // state and bank registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_wr_q      <= 1'b0;
      last_rd_q     <= 1'b1;
      wr_trig_q     <= 1'b0;
      rd_trig_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_bank_q     <= BANK_A;
      rd_bank_q     <= BANK_B;
      newest_bank_q <= BANK_A;
    end else begin
      state_q       <= state_d;
      gnt_wr_q      <= gnt_wr_d;
      last_rd_q     <= last_rd_d;
      wr_trig_q     <= wr_trig_d;
      rd_trig_q     <= rd_trig_d;
      frame_valid_q <= frame_valid_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      newest_bank_q <= newest_bank_d;
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  // count write frames whose bank swap was refused, saturating
  always_comb drop_cnt_d = (wr_fe && hold && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  // drop counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt_q <= 16'd0;
    else        drop_cnt_q <= drop_cnt_d;
  assign frame_drop_cnt = drop_cnt_q;
`endif

  assign wr_trig     = wr_trig_q;
  assign rd_trig     = rd_trig_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign frame_valid = frame_valid_q;
endmodule

// File: tb/tb_sdram_pingpong_sched.sv
// tb_sdram_pingpong_sched: directed self-checking bench for sdram_pingpong_sched with FRAME_BURSTS=4
module tb_sdram_pingpong_sched;
  localparam int FB = 4;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_end = 1'b0;
  logic wr_rdy = 1'b0;
  logic rd_rdy = 1'b0;
  logic wr_burst_end = 1'b0;
  logic rd_burst_end = 1'b0;
  logic wr_trig, rd_trig, frame_valid;
  logic [1:0] wr_bank, rd_bank;
  logic [RW-1:0] wr_row, rd_row;
`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] frame_drop_cnt;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_pingpong_sched #(.FRAME_BURSTS(FB), .ROW_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end), .wr_rdy(wr_rdy), .rd_rdy(rd_rdy),
    .wr_burst_end(wr_burst_end), .rd_burst_end(rd_burst_end),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .wr_row(wr_row), .rd_row(rd_row), .frame_valid(frame_valid)
`ifdef PINGPONG_DROP_CNT_EN
    , .frame_drop_cnt(frame_drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for the next trig, check side/bank/row, optionally complete the burst
  task automatic burst(input string tag, input logic exp_wr, input logic [1:0] exp_bank,
                       input logic [RW-1:0] exp_row, input bit do_end);
    int n = 0;
    while (!(wr_trig || rd_trig) && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, wr_trig | rd_trig}, 32'd1);
    chk({tag, "_side"}, {30'd0, wr_trig, rd_trig}, exp_wr ? 32'd2 : 32'd1);
    chk({tag, "_bank"}, {30'd0, exp_wr ? wr_bank : rd_bank}, {30'd0, exp_bank});
    chk({tag, "_row"}, {30'd0, exp_wr ? wr_row : rd_row}, {30'd0, exp_row});
    if (do_end) begin
      if (exp_wr) wr_burst_end = 1'b1;
      else        rd_burst_end = 1'b1;
      step();
      wr_burst_end = 1'b0;
      rd_burst_end = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_trig"}, {31'd0, wr_trig}, 32'd0);
    chk({tag, "_rd_trig"}, {31'd0, rd_trig}, 32'd0);
    chk({tag, "_wr_bank"}, {30'd0, wr_bank}, 32'd0);
    chk({tag, "_rd_bank"}, {30'd0, rd_bank}, 32'd1);
    chk({tag, "_wr_row"}, {30'd0, wr_row}, 32'd0);
    chk({tag, "_rd_row"}, {30'd0, rd_row}, 32'd0);
    chk({tag, "_fvalid"}, {31'd0, frame_valid}, 32'd0);
`ifdef PINGPONG_DROP_CNT_EN
    chk({tag, "_drop"}, {16'd0, frame_drop_cnt}, 32'd0);
`endif
  endtask

  initial begin
    int cnt;
    repeat (3) step();
    chk_reset("rst");
    rst_n = 1'b1;
    wr_rdy = 1'b1;
    rd_rdy = 1'b1;
    cnt = 0;
    repeat (100) begin
      step();
      if (wr_trig) cnt++;
    end
    chk("no_trig_before_init", cnt, 32'd0);
    init_end = 1'b1;
    step();
    chk("trig_latency_1", {31'd0, wr_trig}, 32'd0);
    step();
    burst("w0", 1'b1, 2'd0, 2'd0, 1'b0);
    step();
    chk("trig_one_cycle", {31'd0, wr_trig}, 32'd0);
    rd_burst_end = 1'b1;
    step();
    rd_burst_end = 1'b0;
    chk("spur_rd_row", {30'd0, rd_row}, 32'd0);
    chk("spur_trigs", {30'd0, wr_trig, rd_trig}, 32'd0);
    step();
    chk("spur_still_busy", {30'd0, wr_trig, rd_trig}, 32'd0);
    chk("spur_wr_row", {30'd0, wr_row}, 32'd0);
    wr_burst_end = 1'b1;
    step();
    wr_burst_end = 1'b0;
    chk("w0_end_row", {30'd0, wr_row}, 32'd1);
    burst("w1", 1'b1, 2'd0, 2'd1, 1'b1);
    burst("w2", 1'b1, 2'd0, 2'd2, 1'b1);
    burst("w3", 1'b1, 2'd0, 2'd3, 1'b1);
    chk("f1_valid", {31'd0, frame_valid}, 32'd1);
    chk("f1_wr_bank", {30'd0, wr_bank}, 32'd1);
    chk("f1_wr_row", {30'd0, wr_row}, 32'd0);
    burst("r00", 1'b0, 2'd0, 2'd0, 1'b1);
    burst("w10", 1'b1, 2'd1, 2'd0, 1'b1);
    burst("r01", 1'b0, 2'd0, 2'd1, 1'b1);
    burst("w11", 1'b1, 2'd1, 2'd1, 1'b1);
    burst("r02", 1'b0, 2'd0, 2'd2, 1'b1);
    burst("w12", 1'b1, 2'd1, 2'd2, 1'b1);
    burst("r03", 1'b0, 2'd0, 2'd3, 1'b1);
    chk("r_wrap_row", {30'd0, rd_row}, 32'd0);
    burst("w13", 1'b1, 2'd1, 2'd3, 1'b1);
    chk("f2_wr_bank", {30'd0, wr_bank}, 32'd0);
    burst("r10", 1'b0, 2'd1, 2'd0, 1'b1);
    burst("w00", 1'b1, 2'd0, 2'd0, 1'b1);
    burst("r11", 1'b0, 2'd1, 2'd1, 1'b1);
    burst("w01", 1'b1, 2'd0, 2'd1, 1'b1);
    rd_rdy = 1'b0;
    burst("w02", 1'b1, 2'd0, 2'd2, 1'b1);
    burst("w03", 1'b1, 2'd0, 2'd3, 1'b1);
    chk("drop_wr_bank", {30'd0, wr_bank}, 32'd0);
    chk("drop_wr_row", {30'd0, wr_row}, 32'd0);
    chk("drop_rd_row", {30'd0, rd_row}, 32'd2);
`ifdef PINGPONG_DROP_CNT_EN
    chk("drop_cnt", {16'd0, frame_drop_cnt}, 32'd1);
`endif
    rd_rdy = 1'b1;
    burst("r12", 1'b0, 2'd1, 2'd2, 1'b1);
    burst("w00b", 1'b1, 2'd0, 2'd0, 1'b1);
    burst("r13", 1'b0, 2'd1, 2'd3, 1'b1);
    burst("w01b", 1'b1, 2'd0, 2'd1, 1'b1);
    burst("r10_repeat", 1'b0, 2'd1, 2'd0, 1'b1);
    burst("w02b", 1'b1, 2'd0, 2'd2, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_latency", {30'd0, wr_trig, rd_trig}, 32'd0);
    step();
    chk("post_rst_trig", {30'd0, wr_trig, rd_trig}, 32'd2);
    burst("w_post0", 1'b1, 2'd0, 2'd0, 1'b1);
    burst("w_post1", 1'b1, 2'd0, 2'd1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
